// File: rtl/mdu_e_if.sv
// rtl/mdu_e_if.sv - E-stage to multiply/divide unit bus: launch request, operands, cancel, busy and HI/LO.
interface mdu_e_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        respon;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output start, op, A, B, respon, input busy, HI, LO);
    modport slave  (input start, op, A, B, respon, output busy, HI, LO);
endinterface

// File: rtl/mdu_e.sv
// rtl/mdu_e.sv - multi-cycle mult/div unit holding HI/LO for the E stage.
// Define MDU_MADD_EN to enable the madd/maddu/msub/msubu accumulate ops (6-9).
module mdu_e #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset,
    mdu_e_if.slave   bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) < 4) ? 4 : $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;
`endif

    typedef enum logic {IDLE, RUN} stateT;

    stateT              state, stateNext;
    logic [CNT_W-1:0]   cnt, cntNext;
    logic [31:0]        resHI, resHINext;
    logic [31:0]        resLO, resLONext;
    logic               wr, wrNext;
    logic [31:0]        hiReg, hiNext;
    logic [31:0]        loReg, loNext;

    logic               launch;
    logic               mulSigned;
    logic [63:0]        mulA, mulB, prod;
    logic               divSigned, negA, negB;
    logic [31:0]        divA, divB, divBSafe;
    logic [31:0]        quoMag, remMag, quo, rem;
`ifdef MDU_MADD_EN
    logic [63:0]        accSum, accDiff;
`endif

    assign launch = bus.start & ~bus.respon & (state == IDLE);

`ifdef MDU_MADD_EN
    assign mulSigned = (bus.op == OP_MULT) | (bus.op == OP_MADD) | (bus.op == OP_MSUB);
`else
    assign mulSigned = (bus.op == OP_MULT);
`endif

    // A 64x64 product of sign- or zero-extended operands gives the correct
    // low 64 bits for both signed and unsigned multiplies with one multiplier.
    assign mulA = {{32{mulSigned & bus.A[31]}}, bus.A};
    assign mulB = {{32{mulSigned & bus.B[31]}}, bus.B};
    assign prod = mulA * mulB;

`ifdef MDU_MADD_EN
    assign accSum  = {hiReg, loReg} + prod;
    assign accDiff = {hiReg, loReg} - prod;
`endif

    // Signed divide runs on magnitudes; quotient sign is the XOR of operand
    // signs and the remainder follows the dividend. -2^31/-1 falls out as
    // quotient 0x80000000, remainder 0.
    assign divSigned = (bus.op == OP_DIV);
    assign negA      = divSigned & bus.A[31];
    assign negB      = divSigned & bus.B[31];
    assign divA      = negA ? -bus.A : bus.A;
    assign divB      = negB ? -bus.B : bus.B;
    assign divBSafe  = (bus.B == 32'd0) ? 32'd1 : divB;
    assign quoMag    = divA / divBSafe;
    assign remMag    = divA % divBSafe;
    assign quo       = (negA ^ negB) ? -quoMag : quoMag;
    assign rem       = negA ? -remMag : remMag;

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        resHINext = resHI;
        resLONext = resLO;
        wrNext    = wr;
        hiNext    = hiReg;
        loNext    = loReg;
        case (state)
            IDLE: begin
                if (launch) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            {resHINext, resLONext} = prod;
                            wrNext    = 1'b1;
                            cntNext   = CNT_W'(MULT_CYCLES);
                            stateNext = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            resHINext = rem;
                            resLONext = quo;
                            wrNext    = (bus.B != 32'd0);
                            cntNext   = CNT_W'(DIV_CYCLES);
                            stateNext = RUN;
                        end
                        OP_MTHI: hiNext = bus.A;
                        OP_MTLO: loNext = bus.A;
`ifdef MDU_MADD_EN
                        OP_MADD, OP_MADDU: begin
                            {resHINext, resLONext} = accSum;
                            wrNext    = 1'b1;
                            cntNext   = CNT_W'(MULT_CYCLES);
                            stateNext = RUN;
                        end
                        OP_MSUB, OP_MSUBU: begin
                            {resHINext, resLONext} = accDiff;
                            wrNext    = 1'b1;
                            cntNext   = CNT_W'(MULT_CYCLES);
                            stateNext = RUN;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cntNext = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    stateNext = IDLE;
                    if (wr) begin
                        hiNext = resHI;
                        loNext = resLO;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            resHI <= 32'd0;
            resLO <= 32'd0;
            wr    <= 1'b0;
            hiReg <= 32'd0;
            loReg <= 32'd0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            resHI <= resHINext;
            resLO <= resLONext;
            wr    <= wrNext;
            hiReg <= hiNext;
            loReg <= loNext;
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.HI   = hiReg;
    assign bus.LO   = loReg;
endmodule

// File: tb/tb_mdu_e.sv
// tb/tb_mdu_e.sv - directed and randomized checks of mdu_e against an arithmetic HI/LO model.
module tb_mdu_e;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_e_if bus ();

    mdu_e #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] mHI = 32'd0;
    logic [31:0] mLO = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int latency(input logic [3:0] op);
        case (op)
            4'd0, 4'd1: return MC;
            4'd2, 4'd3: return DC;
`ifdef MDU_MADD_EN
            4'd6, 4'd7, 4'd8, 4'd9: return MC;
`endif
            default: return 0;
        endcase
    endfunction

    // Architectural effect of one accepted instruction on HI/LO
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        logic [63:0]     p, acc;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        acc = {mHI, mLO};
        case (op)
            4'd0: begin p = sa * sb; {mHI, mLO} = p; end
            4'd1: begin p = ua * ub; {mHI, mLO} = p; end
            4'd2: if (b != 0) begin
                q = sa / sb;
                r = sa % sb;
                mLO = 32'(q);
                mHI = 32'(r);
            end
            4'd3: if (b != 0) begin
                mLO = a / b;
                mHI = a % b;
            end
            4'd4: mHI = a;
            4'd5: mLO = a;
`ifdef MDU_MADD_EN
            4'd6: begin p = sa * sb; {mHI, mLO} = acc + p; end
            4'd7: begin p = ua * ub; {mHI, mLO} = acc + p; end
            4'd8: begin p = sa * sb; {mHI, mLO} = acc - p; end
            4'd9: begin p = ua * ub; {mHI, mLO} = acc - p; end
`endif
            default: ;
        endcase
    endtask

    // Entered and left at a falling edge; drives start in the current cycle T
    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic rsp);
        int n;
        logic [31:0] oHI, oLO;
        oHI = mHI;
        oLO = mLO;
        bus.start  = 1'b1;
        bus.op     = op;
        bus.A      = a;
        bus.B      = b;
        bus.respon = rsp;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.respon = 1'b0;
        bus.A      = $urandom;
        bus.B      = $urandom;
        n = rsp ? 0 : latency(op);
        if (!rsp) model(op, a, b);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("busy_op%0d_c%0d", op, i + 1), {31'd0, bus.busy}, 32'd1);
            chk($sformatf("hold_hi_op%0d", op), bus.HI, oHI);
            chk($sformatf("hold_lo_op%0d", op), bus.LO, oLO);
            @(negedge clk);
        end
        chk($sformatf("idle_op%0d", op), {31'd0, bus.busy}, 32'd0);
        chk($sformatf("hi_op%0d", op), bus.HI, mHI);
        chk($sformatf("lo_op%0d", op), bus.LO, mLO);
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        logic        rrsp;
        int          sel;

        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.op     = 4'd0;
        bus.A      = 32'd0;
        bus.B      = 32'd0;
        bus.respon = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_hi", bus.HI, 32'd0);
        chk("reset_lo", bus.LO, 32'd0);

        run(4'd0, 32'hFFFFFFFE, 32'd3, 1'b0);
        chk("plan_mult_hi", bus.HI, 32'hFFFFFFFF);
        chk("plan_mult_lo", bus.LO, 32'hFFFFFFFA);

        run(4'd3, 32'd7, 32'd2, 1'b0);
        chk("plan_divu_lo", bus.LO, 32'd3);
        chk("plan_divu_hi", bus.HI, 32'd1);

        run(4'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
        chk("plan_div_lo", bus.LO, 32'hFFFFFFFD);
        chk("plan_div_hi", bus.HI, 32'hFFFFFFFF);
        run(4'd2, 32'd1234, 32'd0, 1'b0);
        chk("plan_div0_hi", bus.HI, 32'hFFFFFFFF);

        run(4'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        chk("div_ovf_lo", bus.LO, 32'h80000000);
        chk("div_ovf_hi", bus.HI, 32'd0);

        run(4'd5, 32'h12345678, 32'd0, 1'b1);
        run(4'd5, 32'h12345678, 32'd0, 1'b0);
        chk("plan_mtlo", bus.LO, 32'h12345678);
        run(4'd4, 32'hCAFEF00D, 32'd0, 1'b0);

        // Reset in the third busy cycle of a mult discards the pending result
        bus.start = 1'b1;
        bus.op    = 4'd1;
        bus.A     = 32'd5;
        bus.B     = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_busy", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mHI = 32'd0;
        mLO = 32'd0;
        chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_mid_hi", bus.HI, 32'd0);
        chk("rst_mid_lo", bus.LO, 32'd0);
        repeat (MC + 2) @(negedge clk);
        chk("rst_nocommit_hi", bus.HI, 32'd0);
        chk("rst_nocommit_lo", bus.LO, 32'd0);
        chk("rst_nocommit_busy", {31'd0, bus.busy}, 32'd0);

        run(4'd4, 32'd0, 32'd0, 1'b0);
        run(4'd5, 32'hFFFFFFFF, 32'd0, 1'b0);
        run(4'd7, 32'd1, 32'd1, 1'b0);
`ifdef MDU_MADD_EN
        chk("plan_maddu_hi", bus.HI, 32'd1);
        chk("plan_maddu_lo", bus.LO, 32'd0);
`else
        chk("plan_maddu_hi", bus.HI, 32'd0);
        chk("plan_maddu_lo", bus.LO, 32'hFFFFFFFF);
`endif

        for (int k = 0; k < 60; k++) begin
            rop  = 4'($urandom_range(0, 15));
            ra   = $urandom;
            rb   = $urandom;
            sel  = $urandom_range(0, 7);
            if (sel == 0) rb = 32'd0;
            if (sel == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            if (sel == 2) rb = 32'($urandom_range(1, 9));
            if (sel == 3) rb = -32'($urandom_range(1, 9));
            rrsp = ($urandom_range(0, 4) == 0);
            run(rop, ra, rb, rrsp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
